// File: rtl/issue_scheduler_if.sv
// rtl/issue_scheduler_if.sv - uop type package and issue stage port bundle
package issue_pkg;
  typedef enum logic [2:0] {FU_NONE, FU_ALU, FU_LSU, FU_BRANCH, FU_JUMP} fu_t;

  typedef enum logic [3:0] {
    OP_ALI, OP_ALR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BRANCH, OP_LOAD, OP_STORE, OP_SYS
  } fu_op_t;

  typedef struct packed {
    fu_t         fu;
    fu_op_t      fu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        ebreak;
    logic [11:0] imm;
  } uop_info_t;
endpackage

interface issue_scheduler_if;
  import issue_pkg::*;

  logic        dec_valid_i;
  logic        dec_ready_o;
  uop_info_t   dec_uop_i;
  logic        flush_i;
  uop_info_t   issue_uop_o;
  logic        alu_valid_o;
  logic        alu_ready_i;
  logic        lsu_valid_o;
  logic        lsu_ready_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        lsu_done_i;
  logic        halt_o;
  logic [31:0] stall_cnt_o;

  modport slave (
    input  dec_valid_i, dec_uop_i, flush_i, alu_ready_i, lsu_ready_i,
           wb_valid_i, wb_rd_i, lsu_done_i,
    output dec_ready_o, issue_uop_o, alu_valid_o, lsu_valid_o, halt_o, stall_cnt_o
  );

  modport master (
    output dec_valid_i, dec_uop_i, flush_i, alu_ready_i, lsu_ready_i,
           wb_valid_i, wb_rd_i, lsu_done_i,
    input  dec_ready_o, issue_uop_o, alu_valid_o, lsu_valid_o, halt_o, stall_cnt_o
  );
endinterface

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - single-entry issue slot with scoreboard, LSU credit and ebreak drain
// ISSUE_SB_BYPASS_EN: hazard and drain checks see the same-cycle writeback clear.
module issue_scheduler
  import issue_pkg::*;
#(
  parameter int LSU_MAX_OUT = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  issue_scheduler_if.slave bus
);

  localparam int CW = $clog2(LSU_MAX_OUT + 1);
  localparam logic [CW-1:0] LSU_MAX = CW'(LSU_MAX_OUT);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

  state_e        state_q, state_d;
  logic          slot_v_q, slot_v_d;
  uop_info_t     slot_q, slot_d;
  logic [31:0]   sb_q, sb_d;
  logic [CW-1:0] lsu_cnt_q, lsu_cnt_d;
  logic [31:0]   stall_q, stall_d;

  logic [31:0] wb_clr;
  logic [31:0] sb_chk;
  logic run, is_lsu, rs1_used, rs2_used, hazard;
  logic alu_v, lsu_v, fire, fire_lsu, dec_rdy, accept, cnt_dec;

  assign wb_clr = (bus.wb_valid_i && bus.wb_rd_i != 5'd0) ? (32'd1 << bus.wb_rd_i) : 32'd0;

`ifdef ISSUE_SB_BYPASS_EN
  assign sb_chk = sb_q & ~wb_clr;
`else
  assign sb_chk = sb_q;
`endif

  assign run      = (state_q == RUN);
  assign is_lsu   = (slot_q.fu == FU_LSU);
  assign rs1_used = !(slot_q.fu_op inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign rs2_used = slot_q.fu_op inside {OP_ALR, OP_STORE, OP_BRANCH};
  assign hazard   = (rs1_used && sb_chk[slot_q.rs1]) ||
                    (rs2_used && sb_chk[slot_q.rs2]) ||
                    (slot_q.rd_wen && sb_chk[slot_q.rd]);

  // Flush squashes the held uop this cycle, so it must never reach an FU.
  assign alu_v = run && slot_v_q && !bus.flush_i && !slot_q.ebreak && !is_lsu && !hazard;
  assign lsu_v = run && slot_v_q && !bus.flush_i && !slot_q.ebreak && is_lsu && !hazard &&
                 (lsu_cnt_q < LSU_MAX);

  assign fire_lsu = lsu_v && bus.lsu_ready_i;
  assign fire     = (alu_v && bus.alu_ready_i) || fire_lsu;
  assign dec_rdy  = run && !bus.flush_i && (!slot_v_q || fire);
  assign accept   = bus.dec_valid_i && dec_rdy;
  assign cnt_dec  = bus.lsu_done_i && (lsu_cnt_q != '0);

  always_comb begin
    sb_d = sb_q & ~wb_clr;
    if (fire && slot_q.rd_wen && slot_q.rd != 5'd0) begin
      sb_d = sb_d | (32'd1 << slot_q.rd);
    end

    lsu_cnt_d = lsu_cnt_q;
    if (fire_lsu && !cnt_dec) begin
      lsu_cnt_d = lsu_cnt_q + CW'(1);
    end else if (!fire_lsu && cnt_dec) begin
      lsu_cnt_d = lsu_cnt_q - CW'(1);
    end

    slot_v_d = slot_v_q;
    slot_d   = slot_q;
    if (bus.flush_i) begin
      slot_v_d = 1'b0;
    end else if (accept) begin
      slot_v_d = 1'b1;
      slot_d   = bus.dec_uop_i;
    end else if (fire || (run && slot_v_q && slot_q.ebreak)) begin
      slot_v_d = 1'b0;
    end

    stall_d = stall_q;
    if (run && slot_v_q && !fire && !slot_q.ebreak && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end

    state_d = state_q;
    case (state_q)
      RUN: begin
        if (!bus.flush_i && slot_v_q && slot_q.ebreak) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.flush_i) state_d = RUN;
        else if (sb_chk == 32'd0 && lsu_cnt_q == '0) state_d = HALT;
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      slot_v_q  <= 1'b0;
      slot_q    <= '0;
      sb_q      <= 32'd0;
      lsu_cnt_q <= '0;
      stall_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      slot_v_q  <= slot_v_d;
      slot_q    <= slot_d;
      sb_q      <= sb_d;
      lsu_cnt_q <= lsu_cnt_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.dec_ready_o = dec_rdy;
  assign bus.issue_uop_o = slot_q;
  assign bus.alu_valid_o = alu_v;
  assign bus.lsu_valid_o = lsu_v;
  assign bus.halt_o      = (state_q == HALT);
  assign bus.stall_cnt_o = stall_q;

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Single-entry issue stage between `decoder` and the functional units. It holds one decoded `uop_info_t`, checks it against a 32-entry register scoreboard and an LSU outstanding-operation counter, and dispatches it to the ALU or LSU port under valid/ready handshakes. It also sequences `ebreak` by draining all in-flight work before asserting halt, and squashes the held uop on a front-end flush.

## Interface
- `LSU_MAX_OUT`, default 2: maximum LSU operations issued but not yet completed (1..8).
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `dec_valid_i`  in  1  decoder offers a uop
- `dec_ready_o`  out  1  slot can accept this cycle
- `dec_uop_i`  in  uop_info_t  decoded uop
- `flush_i`  in  1  squash the held uop (redirect)
- `issue_uop_o`  out  uop_info_t  held uop, shared by both FU ports
- `alu_valid_o` / `alu_ready_i`  out/in  1  ALU dispatch handshake
- `lsu_valid_o` / `lsu_ready_i`  out/in  1  LSU dispatch handshake
- `wb_valid_i`  in  1  register writeback occurring
- `wb_rd_i`  in  5  writeback destination
- `lsu_done_i`  in  1  one LSU operation completed (load or store)
- `halt_o`  out  1  core halted after ebreak drain
- `stall_cnt_o`  out  32  cycles with slot valid but not dispatched

## Operation
- State: `slot_v` and `slot_uop` (one entry), `sb[31:0]`, `lsu_cnt` with width $clog2(LSU_MAX_OUT+1), FSM {RUN, DRAIN, HALT}, and `stall_cnt`.
- Routing: `fu==FU_LSU` goes to the LSU port; all other uops (ALU, branch, jump, LUI, AUIPC, FU_NONE) go to the ALU port. `ebreak` never dispatches.
- rs1 is used unless `fu_op` is in {LUI, AUIPC, JAL}. rs2 is used when `fu_op` is in {ALR, STORE, BRANCH}. Register x0 is never busy.
- `hazard` = (rs1 used and sb[rs1]) or (rs2 used and sb[rs2]) or (rd_wen and sb[rd]).
- `alu_valid_o` = RUN & slot_v & !ebreak & route==ALU & !hazard.
- `lsu_valid_o` = RUN & slot_v & route==LSU & !hazard & lsu_cnt<LSU_MAX_OUT.
- `fire` = dispatched valid & matching ready. On fire: if rd_wen, set sb[rd]; if LSU, increment lsu_cnt.
- Writeback: `wb_valid_i` with wb_rd_i≠0 clears sb[wb_rd_i]. If the same cycle sets the same index, the set wins.
- `lsu_done_i` decrements lsu_cnt. Simultaneous increment and decrement leaves it unchanged. A decrement at 0 is ignored.
- `dec_ready_o` = RUN & !flush_i & (!slot_v | fire). Accept loads the slot; slot_v clears on fire without accept.
- FSM:
  - RUN to DRAIN when the slot holds ebreak. The slot is consumed on entry and `dec_ready_o`=0.
  - DRAIN to HALT when sb==0 and lsu_cnt==0.
  - DRAIN to RUN on `flush_i` (speculative ebreak cancelled).
  - HALT is terminal until reset. `halt_o`=1 in HALT only.
- `flush_i` clears slot_v next edge, and has priority over accept and fire that cycle: valids are forced 0. sb and lsu_cnt are untouched.
- `stall_cnt` increments (saturating at 2^32−1) each RUN cycle with slot_v & !fire & !ebreak.
- `issue_uop_o` is the slot register directly (no combinational path from `dec_uop_i`).

## Timing
- Reset values: slot_v=0, sb=0, lsu_cnt=0, FSM=RUN, stall_cnt=0; all valids 0, `dec_ready_o`=1, `halt_o`=0. `issue_uop_o` resets to all-zero.
- Accept at edge N gives dispatch valid during cycle N+1 if hazard-free. Back-to-back independent uops sustain 1 per cycle.
- A dependent uop issues no earlier than the cycle its producer's writeback clears the scoreboard (see Configuration).
- Valid is held stable with `issue_uop_o` until fire or flush. The FU may take any number of cycles to assert ready.
- Reset asserted mid-operation discards the slot, scoreboard and counter immediately.

## Configuration
- `ISSUE_SB_BYPASS_EN` defined: the hazard check uses sb with the same-cycle `wb_valid_i`/`wb_rd_i` clear applied. A consumer dispatches in the writeback cycle.
- Not defined: the hazard check uses registered sb only. A consumer dispatches one cycle after writeback. The DRAIN exit also sees the registered sb.

## Test plan
- Independent ALU uops `addi x1`, `addi x2` offered back-to-back with ALU ready=1 → alu fires in consecutive cycles; sb=0x6 after both.
- RAW hazard: `addi x5` then `add x6,x5,x5`; writeback of x5 in cycle W → second fires in cycle W with bypass, W+1 without; stall_cnt counts the waiting cycles.
- LSU_MAX_OUT=2: three `sw` in a row, lsu_done_i held low → two fire, third waits with lsu_valid_o=0; one lsu_done_i pulse → third fires next cycle.
- ebreak with one `lw x3` outstanding → DRAIN and dec_ready_o=0; after lsu_done_i and wb of x3 → HALT, halt_o=1, held until reset.
- flush_i while the slot holds a hazard-stalled uop and dec_valid_i=1 → no fire, slot empty next cycle, sb unchanged. Same test in DRAIN → returns to RUN, halt_o stays 0.
- rst_ni low while sb=0xFFFFFFFE and lsu_cnt=2 → all state clears asynchronously; the first uop after release issues without stall.
